// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: MEM-stage load/store sequencer for a word-wide synchronous RAM.
// Build option: define SUBWORD_BE_EN to write sub-word stores with byte enables instead of read-modify-write.
module subword_mem_ctrl #(
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int RAM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for req
  // ERR   | addr_err pulse, no RAM access
  // RD    | RAM read issued
  // LDRET | RAM data returned, extended load result on rdata, done
  // MERGE | RAM data returned, store lane merged into the word
  // WR    | RAM write issued, done

  if (RAM_LAT != 1) begin : g_ram_lat_check
    $error("subword_mem_ctrl: only RAM_LAT=1 is supported");
  end

`ifdef SUBWORD_BE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_RD, S_LDRET, S_MERGE, S_WR} state_t;

  state_t      state;
  logic        op_we;
  logic        op_sext;
  logic [1:0]  op_size;
  logic [1:0]  op_off;
  logic [15:0] op_wdata;
  logic [31:0] rdata_q;

  logic        req_bad;
  logic        direct_wr;
  logic [1:0]  in_lane;
  logic        in_half;
  logic [3:0]  in_be;
  logic [31:0] in_wdata_rep;
  logic [1:0]  op_lane;
  logic        op_half;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  function automatic logic [1:0] byte_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  function automatic logic half_lane(input logic off1);
    return BIG_ENDIAN ? ~off1 : off1;
  endfunction

  always_comb begin
    req_bad = (size == 2'b11) ||
              (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
    direct_wr    = we && ((size == 2'b10) || BE_EN);
    in_lane      = byte_lane(addr[1:0]);
    in_half      = half_lane(addr[1]);
    in_be        = 4'hF;
    in_wdata_rep = wdata;
    case (size)
      2'b00: begin
        in_be        = 4'b0001 << in_lane;
        in_wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        in_be        = in_half ? 4'b1100 : 4'b0011;
        in_wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        in_be        = 4'hF;
        in_wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    op_lane = byte_lane(op_off);
    op_half = half_lane(op_off[1]);
    ld_byte = mem_rdata[{op_lane, 3'b000} +: 8];
    ld_half = mem_rdata[{op_half, 4'b0000} +: 16];
    ld_ext  = mem_rdata;
    case (op_size)
      2'b00:   ld_ext = {{24{op_sext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{op_sext & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (op_size == 2'b00) merged[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
    else                  merged[{op_half, 4'b0000} +: 16] = op_wdata;
  end

  // RAM data is only valid in the LDRET cycle, so the load result passes straight
  // through then and is held in rdata_q until the next load completes.
  assign rdata = (state == S_LDRET) ? ld_ext : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      op_we     <= 1'b0;
      op_sext   <= 1'b0;
      op_size   <= 2'b00;
      op_off    <= 2'b00;
      op_wdata  <= '0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= 4'h0;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_we    <= we;
            op_sext  <= sign_ext;
            op_size  <= size;
            op_off   <= addr[1:0];
            op_wdata <= wdata[15:0];
            mem_addr <= addr[31:2];
            busy     <= 1'b1;
            if (req_bad) begin
              state    <= S_ERR;
              addr_err <= 1'b1;
            end else if (direct_wr) begin
              state     <= S_WR;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_be    <= in_be;
              mem_wdata <= in_wdata_rep;
              done      <= 1'b1;
            end else begin
              state  <= S_RD;
              mem_en <= 1'b1;
              mem_be <= 4'hF;
            end
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_RD: begin
          if (op_we) begin
            state <= S_MERGE;
          end else begin
            state <= S_LDRET;
            done  <= 1'b1;
          end
        end
        S_LDRET: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          rdata_q <= ld_ext;
        end
        S_MERGE: begin
          state     <= S_WR;
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_be    <= 4'hF;
          mem_wdata <= merged;
          done      <= 1'b1;
        end
        S_WR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Bench for subword_mem_ctrl: a small synchronous RAM plus a byte-level model of memory contents.
// Honours SUBWORD_BE_EN when the design is built with it.
module tb_subword_mem_ctrl;

  localparam bit TB_BE = 1'b0;
`ifdef SUBWORD_BE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  subword_mem_ctrl #(.BIG_ENDIAN(TB_BE), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:15];
  logic        poke = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'd0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (poke) begin
      ram[poke_idx] <= poke_val;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr[3:0]];
      end
    end
  end

  logic [31:0] mdl [0:15];
  logic [31:0] last_rd = 32'd0;
  int n_checks = 0;
  int n_pass = 0;

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    return (nbytes(sz) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes(sz))) - 32'd1);
  endfunction

  function automatic int unsigned lane_shift(input logic [31:0] a, input logic [1:0] sz);
    int unsigned o;
    o = a % 4;
    return TB_BE ? (4 - o - nbytes(sz)) * 8 : o * 8;
  endfunction

  function automatic logic legal(input logic [31:0] a, input logic [1:0] sz);
    return (sz != 2'b11) && ((a % nbytes(sz)) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] m;
    logic [31:0] v;
    m = lane_mask(sz);
    v = (mdl[a[5:2]] >> lane_shift(a, sz)) & m;
    if (sx && ((v & (m ^ (m >> 1))) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    m = lane_mask(sz) << lane_shift(a, sz);
    return (mdl[a[5:2]] & ~m) | ((wd << lane_shift(a, sz)) & m);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] m;
    logic [3:0]  be;
    m = lane_mask(sz) << lane_shift(a, sz);
    for (int i = 0; i < 4; i++) be[i] = (((m >> (8 * i)) & 32'hFF) != 0);
    return be;
  endfunction

  task automatic poke_word(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk);
    #1 poke = 1'b0;
    mdl[idx] = val;
  endtask

  // Issues one request and records what the DUT does, cycle by cycle after the accept edge.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int dc, output int ec, output int ecnt,
                            output logic [31:0] rd, output logic [31:0] wrd, output logic [3:0] wbe,
                            output logic [31:0] ea, output logic b1, output logic ba);
    dc = -1; ec = -1; ecnt = 0; rd = 'x; wrd = 'x; wbe = 'x; ea = 'x; b1 = 1'b0; ba = 1'b1;
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    we = ~w; size = ~sz; addr = $urandom(); wdata = $urandom();
    for (int k = 1; k <= 8 && dc < 0 && ec < 0; k++) begin
      @(negedge clk);
      if (k == 1) b1 = busy;
      if (mem_en) begin ecnt++; ea = {2'b00, mem_addr}; end
      if (mem_en && mem_we) begin wrd = mem_wdata; wbe = mem_be; end
      if (done) begin dc = k; rd = rdata; end
      if (addr_err) ec = k;
    end
    @(negedge clk);
    ba = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, addr_err, mem_en, mem_we} !== 5'b0)
      $display("FAIL reset_ctrl: busy/done/err/en/we=%b want 00000", {busy, done, addr_err, mem_en, mem_we});
    else n_pass++;
    n_checks++;
    if (mem_be !== 4'h0) $display("FAIL reset_be: got %h want 0", mem_be); else n_pass++;
    n_checks++;
    if ({rdata, mem_wdata, mem_addr} !== '0)
      $display("FAIL reset_data: rdata=%h wdata=%h maddr=%h want 0", rdata, mem_wdata, mem_addr);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    int dc, ec, ecnt; logic [31:0] rd, wrd, ea; logic [3:0] wbe; logic b1, ba;
    poke_word(4'd4, 32'h8001_7FFF);
    run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (dc != 2 || rd !== 32'hFFFF_8001) $display("FAIL lh_sext: cycle %0d data %h want 2 ffff8001", dc, rd);
    else n_pass++;
    run_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (dc != 2 || rd !== 32'h0000_8001) $display("FAIL lhu: cycle %0d data %h want 2 00008001", dc, rd);
    else n_pass++;
    run_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (dc != 2 || rd !== 32'h0000_007F) $display("FAIL lb_pos: cycle %0d data %h want 2 0000007f", dc, rd);
    else n_pass++;
    run_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (dc != 2 || rd !== 32'hFFFF_FF80) $display("FAIL lb_neg: cycle %0d data %h want 2 ffffff80", dc, rd);
    else n_pass++;
    n_checks++;
    if (rdata !== 32'hFFFF_FF80) $display("FAIL rdata_hold: got %h want ffffff80", rdata); else n_pass++;
    last_rd = 32'hFFFF_FF80;
  endtask

  task automatic test_store_byte();
    int dc, ec, ecnt; logic [31:0] rd, wrd, ea; logic [3:0] wbe; logic b1, ba;
    poke_word(4'd2, 32'h1122_3344);
    run_access(1'b1, 2'b00, 1'b0, 32'h0A, 32'h0000_00AB, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    mdl[2] = 32'h11AB_3344;
    n_checks++;
    if (dc != (BE_EN ? 1 : 3)) $display("FAIL sb_latency: cycle %0d want %0d", dc, BE_EN ? 1 : 3);
    else n_pass++;
    n_checks++;
    if (wbe !== (BE_EN ? 4'b0100 : 4'hF)) $display("FAIL sb_be: got %b want %b", wbe, BE_EN ? 4'b0100 : 4'hF);
    else n_pass++;
    n_checks++;
    if (!BE_EN && wrd !== 32'h11AB_3344) $display("FAIL sb_wdata: got %h want 11ab3344", wrd);
    else if (BE_EN && wrd[23:16] !== 8'hAB) $display("FAIL sb_wdata: got %h want lane2 ab", wrd);
    else n_pass++;
    n_checks++;
    if (ram[2] !== 32'h11AB_3344) $display("FAIL sb_ram: got %h want 11ab3344", ram[2]); else n_pass++;
    n_checks++;
    if (rdata !== last_rd) $display("FAIL sb_rdata_hold: got %h want %h", rdata, last_rd); else n_pass++;
  endtask

  task automatic test_misaligned();
    int dc, ec, ecnt; logic [31:0] rd, wrd, ea; logic [3:0] wbe; logic b1, ba;
    int w0;
    w0 = wr_cnt;
    run_access(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (ec != 1 || dc != -1 || ecnt != 0 || b1 !== 1'b1 || ba !== 1'b0)
      $display("FAIL sh_misaligned: err_cyc %0d done_cyc %0d en %0d busy1 %b busy2 %b want 1 -1 0 1 0",
               ec, dc, ecnt, b1, ba);
    else n_pass++;
    run_access(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (ec != 1 || dc != -1 || ecnt != 0 || b1 !== 1'b1 || ba !== 1'b0)
      $display("FAIL size_reserved: err_cyc %0d done_cyc %0d en %0d busy1 %b busy2 %b want 1 -1 0 1 0",
               ec, dc, ecnt, b1, ba);
    else n_pass++;
    n_checks++;
    if (wr_cnt != w0) $display("FAIL err_no_write: writes %0d want %0d", wr_cnt, w0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [31:0] r1, r2, e1, e2; logic b3;
    d1 = -1; d2 = -1; r1 = 'x; r2 = 'x; b3 = 1'b1;
    e1 = m_load(32'h20, 2'b10, 1'b0);
    e2 = m_load(32'h26, 2'b01, 1'b1);
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; req = 1'b1;
    @(posedge clk);
    #1 size = 2'b01; sign_ext = 1'b1; addr = 32'h26;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) b3 = busy;
      if (k == 4) req = 1'b0;
      if (done) begin
        if (d1 < 0) begin d1 = k; r1 = rdata; end
        else if (d2 < 0) begin d2 = k; r2 = rdata; end
      end
    end
    n_checks++;
    if (d1 != 2 || d2 != 5) $display("FAIL b2b_timing: done at %0d,%0d want 2,5", d1, d2); else n_pass++;
    n_checks++;
    if (r1 !== e1 || r2 !== e2) $display("FAIL b2b_data: got %h,%h want %h,%h", r1, r2, e1, e2); else n_pass++;
    n_checks++;
    if (b3 !== 1'b0) $display("FAIL b2b_busy: busy after done %b want 0", b3); else n_pass++;
    last_rd = e2;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic w, sx; logic [1:0] sz; logic [31:0] a, wd, exp;
      int dc, ec, ecnt; logic [31:0] rd, wrd, ea; logic [3:0] wbe; logic b1, ba;
      w  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'b01) a[1] = 1'($urandom_range(0, 1));
      wd = $urandom();
      run_access(w, sz, sx, a, wd, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
      n_checks++;
      if (!legal(a, sz)) begin
        if (ec != 1 || dc != -1 || ecnt != 0)
          $display("FAIL rand_err[%0d]: a=%h sz=%0d err %0d done %0d en %0d", i, a, sz, ec, dc, ecnt);
        else n_pass++;
      end else if (!w) begin
        exp = m_load(a, sz, sx);
        if (dc != 2 || ec != -1 || rd !== exp || ea !== {2'b00, a[31:2]})
          $display("FAIL rand_load[%0d]: a=%h sz=%0d cyc %0d data %h maddr %h want 2 %h %h",
                   i, a, sz, dc, rd, ea, exp, a[31:2]);
        else n_pass++;
        last_rd = exp;
      end else begin
        exp = m_store(a, sz, wd);
        mdl[a[5:2]] = exp;
        if (dc != ((sz == 2'b10 || BE_EN) ? 1 : 3) || ec != -1 || ram[a[5:2]] !== exp ||
            wbe !== (BE_EN ? m_be(a, sz) : 4'hF) || ea !== {2'b00, a[31:2]})
          $display("FAIL rand_store[%0d]: a=%h sz=%0d cyc %0d ram %h be %b want %h", i, a, sz, dc,
                   ram[a[5:2]], wbe, exp);
        else n_pass++;
      end
      n_checks++;
      if (rdata !== last_rd || ba !== 1'b0)
        $display("FAIL rand_hold[%0d]: rdata %h busy %b want %h 0", i, rdata, ba, last_rd);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int dc, ec, ecnt; logic [31:0] rd, wrd, ea; logic [3:0] wbe; logic b1, ba;
    int w0;
    poke_word(4'd6, 32'hC0FF_EE11);
    w0 = wr_cnt;
    @(negedge clk);
    we = !BE_EN; size = BE_EN ? 2'b10 : 2'b00; sign_ext = 1'b0;
    addr = BE_EN ? 32'h18 : 32'h19; wdata = 32'h77; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    if (!BE_EN) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, addr_err, mem_en, mem_we, mem_be} !== 9'b0 || rdata !== 32'd0)
      $display("FAIL abort_outputs: ctrl %b rdata %h want 0", {busy, done, addr_err, mem_en, mem_we, mem_be}, rdata);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cnt != w0 || ram[6] !== mdl[6])
      $display("FAIL abort_no_write: writes %0d ram %h want %0d %h", wr_cnt, ram[6], w0, mdl[6]);
    else n_pass++;
    run_access(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, dc, ec, ecnt, rd, wrd, wbe, ea, b1, ba);
    n_checks++;
    if (dc != 2 || rd !== mdl[6]) $display("FAIL abort_reload: cycle %0d data %h want 2 %h", dc, rd, mdl[6]);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) poke_word(4'(i), $urandom());
    test_loads();
    test_store_byte();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
